// File: rtl/life_scan_reader_if.sv
// Cell stream from the life scan reader to the display/UART side.
// One cell per transfer, row-major, valid/ready handshake.
//   out_valid / out_ready : handshake
//   out_bit               : snapshot alive bit of the presented cell
//   out_row / out_col     : coordinates of the presented cell
//   out_eol / out_last    : end of row / end of frame markers
// master = reader (source), slave = consumer.
interface life_scan_reader_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int CW   = (COLS > 1) ? $clog2(COLS) : 1
);
  logic          out_valid;
  logic          out_ready;
  logic          out_bit;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          out_eol;
  logic          out_last;

  modport master (
    output out_valid, out_bit, out_row, out_col, out_eol, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_bit, out_row, out_col, out_eol, out_last,
    output out_ready
  );
endinterface

// File: rtl/life_scan_reader.sv
// Readback engine for the Life cell array.
// On start (in IDLE) the whole alive vector is snapshotted in one cycle and
// streamed out one cell per transfer, row-major, over out_if. A live-cell
// population count is accumulated and published in the single DONE cycle.
//   clk, reset : clock, synchronous active-high reset
//   start      : request one frame (ignored unless idle)
//   cells      : alive bits, cell (r,c) at bit r*COLS+c
//   busy       : high in STREAM and DONE
//   done       : one-cycle pulse after the last transfer
//   pop_count  : live cells in the last completed frame
//   out_if     : cell stream (master side)
module life_scan_reader #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int CW   = (COLS > 1) ? $clog2(COLS) : 1,
  parameter int PW   = $clog2(ROWS*COLS+1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ROWS*COLS-1:0]   cells,
  output logic                   busy,
  output logic                   done,
  output logic [PW-1:0]          pop_count,
  life_scan_reader_if.master     out_if
);
  localparam int N  = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, FIN} state_t;

  state_t         state;
  logic [N-1:0]   snap;
  logic [RW-1:0]  row;
  logic [CW-1:0]  col;
  logic [PW-1:0]  acc;
  logic           valid;
  logic [IW-1:0]  idx;
  logic           cur_bit;
  logic           at_eol;
  logic           at_last;

  assign idx     = IW'(row * COLS + col);
  assign cur_bit = snap[idx];
  assign at_eol  = (col == CW'(COLS - 1));
  assign at_last = at_eol && (row == RW'(ROWS - 1));

  // Markers are qualified with valid so the idle/reset view is all zero,
  // even in the degenerate COLS=1 case where col==COLS-1 always holds.
  assign out_if.out_valid = valid;
  assign out_if.out_bit   = valid & cur_bit;
  assign out_if.out_row   = row;
  assign out_if.out_col   = col;
  assign out_if.out_eol   = valid & at_eol;
  assign out_if.out_last  = valid & at_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      snap      <= '0;
      row       <= '0;
      col       <= '0;
      acc       <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pop_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snap  <= cells;
            row   <= '0;
            col   <= '0;
            acc   <= '0;
            valid <= 1'b1;
            busy  <= 1'b1;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (out_if.out_ready) begin
            acc <= acc + PW'(cur_bit);
            if (at_last) begin
              // Publish including the cell being transferred right now.
              pop_count <= acc + PW'(cur_bit);
              done      <= 1'b1;
              valid     <= 1'b0;
              row       <= '0;
              col       <= '0;
              state     <= FIN;
            end else if (at_eol) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_life_scan_reader.sv
// Scoreboard bench for life_scan_reader: an 8x8 instance for the main frames
// and a 1x1 instance for the degenerate case. Stimulus pushes expected cells
// and population counts into queues; per-instance monitors pop and compare.
module tb_life_scan_reader;
  logic        clk = 1'b0;
  logic        reset;
  logic        start8, start1;
  logic [63:0] cells8;
  logic [0:0]  cells1;
  logic        busy8, done8, busy1, done1;
  logic [6:0]  pop8;
  logic [0:0]  pop1;

  int checks = 0;
  int errors = 0;
  int done8_cnt = 0;
  int done1_cnt = 0;

  logic [8:0] exp8_q[$];
  int         pop8_q[$];
  logic [4:0] exp1_q[$];
  int         pop1_q[$];

  logic [8:0] cur8, held8;
  logic       hold8 = 1'b0;
  logic [4:0] cur1, held1;
  logic       hold1 = 1'b0;

  always #5 clk = ~clk;

  life_scan_reader_if #(.ROWS(8), .COLS(8)) if8 ();
  life_scan_reader_if #(.ROWS(1), .COLS(1)) if1 ();

  life_scan_reader #(.ROWS(8), .COLS(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .cells(cells8),
    .busy(busy8), .done(done8), .pop_count(pop8), .out_if(if8.master)
  );

  life_scan_reader #(.ROWS(1), .COLS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .cells(cells1),
    .busy(busy1), .done(done1), .pop_count(pop1), .out_if(if1.master)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // 8x8 monitor
  always @(negedge clk) begin
    cur8 = {if8.out_bit, if8.out_row, if8.out_col, if8.out_eol, if8.out_last};
    if (!reset) begin
      if (hold8) chk("hold8", {if8.out_valid, cur8}, {1'b1, held8});
      if (if8.out_valid && if8.out_ready) begin
        if (exp8_q.size() == 0) chk("xfer8_unexpected", cur8, 9'h0);
        else chk("xfer8", cur8, exp8_q.pop_front());
      end
      if (done8) begin
        done8_cnt++;
        if (pop8_q.size() == 0) chk("done8_unexpected", pop8, 7'h7f);
        else chk("pop8", pop8, pop8_q.pop_front());
        chk("done8_valid", if8.out_valid, 1'b0);
      end
    end
    hold8 = !reset && if8.out_valid && !if8.out_ready;
    held8 = cur8;
  end

  // 1x1 monitor
  always @(negedge clk) begin
    cur1 = {if1.out_bit, if1.out_row, if1.out_col, if1.out_eol, if1.out_last};
    if (!reset) begin
      if (hold1) chk("hold1", {if1.out_valid, cur1}, {1'b1, held1});
      if (if1.out_valid && if1.out_ready) begin
        if (exp1_q.size() == 0) chk("xfer1_unexpected", cur1, 5'h0);
        else chk("xfer1", cur1, exp1_q.pop_front());
      end
      if (done1) begin
        done1_cnt++;
        if (pop1_q.size() == 0) chk("done1_unexpected", pop1, 1'b0);
        else chk("pop1", pop1, pop1_q.pop_front());
      end
    end
    hold1 = !reset && if1.out_valid && !if1.out_ready;
    held1 = cur1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame8(input logic [63:0] vec);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        exp8_q.push_back({vec[r*8+c], 3'(r), 3'(c), c == 7, (r == 7) && (c == 7)});
  endtask

  // Runs one 8x8 frame. rnd toggles out_ready; disturb changes cells after
  // the start edge and re-asserts start mid-frame.
  task automatic frame8(input logic [63:0] vec, input int pop, input bit rnd,
                        input bit disturb, input int exp_busy);
    int n;
    int d0;
    push_frame8(vec);
    pop8_q.push_back(pop);
    d0 = done8_cnt;
    cells8 = vec;
    rdy_set8(1'b1);
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n = 0;
    while (busy8 && n < 2000) begin
      if (rnd) rdy_set8(1'($urandom_range(0, 1)));
      if (disturb && n == 1) cells8 = '1;
      if (disturb) start8 = (n == 5);
      n++;
      tick();
    end
    start8 = 1'b0;
    rdy_set8(1'b1);
    chk("busy_bounded", n < 2000, 1'b1);
    if (exp_busy > 0) chk("busy_len", n, exp_busy);
    chk("done_count", done8_cnt - d0, 1);
    chk("queue_drained", exp8_q.size(), 0);
  endtask

  task automatic rdy_set8(input logic v);
    if8.out_ready = v;
  endtask

  initial begin
    reset = 1'b1;
    start8 = 1'b0; start1 = 1'b0;
    cells8 = '0; cells1 = '0;
    if8.out_ready = 1'b1;
    if1.out_ready = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst8_ctl", {busy8, done8, if8.out_valid, pop8}, 10'h0);
    chk("rst8_out", {if8.out_bit, if8.out_row, if8.out_col, if8.out_eol, if8.out_last}, 9'h0);
    chk("rst1_ctl", {busy1, done1, if1.out_valid, pop1, if1.out_eol, if1.out_last}, 6'h0);
    reset = 1'b0;
    tick();

    // All dead: 64 zero cells, pop 0, busy 65 cycles
    frame8(64'h0, 0, 1'b0, 1'b0, 65);
    // Corner cells (0,0) and (7,7)
    frame8(64'h8000_0000_0000_0001, 2, 1'b0, 1'b0, 65);
    // Glider with random backpressure
    frame8(64'h0000_0000_0007_0402, 5, 1'b1, 1'b0, 0);
    chk("pop_hold_glider", pop8, 5);
    // Snapshot isolation and ignored mid-frame start
    frame8(64'h0000_0000_0000_00F0, 4, 1'b0, 1'b1, 65);
    chk("pop_after_ignored_start", pop8, 4);

    // Reset mid-frame: abort, no done, pop cleared
    begin
      int d0;
      d0 = done8_cnt;
      push_frame8(64'h00FF_00FF_00FF_00FF);
      cells8 = 64'h00FF_00FF_00FF_00FF;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      repeat (19) tick();
      reset = 1'b1;
      tick();
      chk("abort_ctl", {if8.out_valid, busy8, done8, pop8}, 10'h0);
      exp8_q.delete();
      reset = 1'b0;
      tick();
      chk("abort_no_done", {done8, busy8}, 2'b00);
      chk("abort_done_count", done8_cnt - d0, 0);
    end
    // Clean full frame after the abort
    frame8(64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0, 1'b0, 65);
    chk("pop_full", pop8, 64);

    // 1x1 degenerate array with 3 stalled cycles
    cells1 = 1'b1;
    exp1_q.push_back(5'b1_0_0_1_1);
    pop1_q.push_back(1);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (3) begin
      chk("stall1", {if1.out_valid, if1.out_eol, if1.out_last, if1.out_bit, busy1}, 5'h1f);
      tick();
    end
    if1.out_ready = 1'b1;
    chk("xfer_cycle1", {if1.out_valid, done1}, 2'b10);
    tick();
    chk("done_cycle1", {done1, if1.out_valid, busy1, pop1}, 4'b1011);
    tick();
    chk("idle_after1", {done1, busy1, pop1}, 3'b001);
    chk("done1_count", done1_cnt, 1);
    chk("queue1_drained", exp1_q.size() + pop1_q.size(), 0);
    chk("pop8_queue_drained", pop8_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/life_scan_reader.md
Name: life_scan_reader

Overview:
Readback engine for the Life cell array: the read side of the cell write/val scan-load path. On a start request it snapshots the flattened alive vector of the whole array in one cycle. It then streams the snapshot out one cell per transfer, row-major, over a valid/ready handshake to the display/UART side. While streaming, it accumulates a live-cell population count that is published at frame end.

Parameters:
ROWS, 8, number of array rows (>=1)
COLS, 8, number of array columns (>=1)
RW, $clog2(ROWS) (min 1), row index width
CW, $clog2(COLS) (min 1), column index width
PW, $clog2(ROWS*COLS+1), population count width

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request one readback frame; honoured only in IDLE
cells  input  ROWS*COLS  alive bits; cell (r,c) at bit r*COLS+c
busy  output  1  high in STREAM and DONE
out_valid  output  1  out_* fields hold a cell
out_ready  input  1  consumer accepts the current cell
out_bit  output  1  snapshot alive bit of current cell
out_row  output  RW  row of current cell
out_col  output  CW  column of current cell
out_eol  output  1  current cell is col COLS-1
out_last  output  1  current cell is (ROWS-1, COLS-1)
done  output  1  one-cycle pulse after the last transfer
pop_count  output  PW  live cells in last completed frame

Behaviour:
- Reset, synchronous, active-high: state=IDLE, busy=0, out_valid=0, out_bit=0, out_row=0, out_col=0, out_eol=0, out_last=0, done=0, pop_count=0. The snapshot register and accumulator are cleared.
- States: IDLE, STREAM, DONE.
- IDLE: start=1 at edge k loads snapshot<=cells, row=col=0, acc=0, and moves to STREAM. At cycle k+1: busy=1, out_valid=1, cell (0,0) is presented. start=0 keeps the block in IDLE.
- STREAM: out_valid=1 continuously. A transfer occurs on any edge with out_valid && out_ready.
  - On transfer: acc<=acc+out_bit.
  - If col<COLS-1, col++. Otherwise col<=0 and row++.
  - If out_last, go to DONE instead.
- Without out_ready, all out_* fields hold stable. There are no bubbles: one cell per cycle when ready is held high.
- out_bit is always snapshot[row*COLS+col]. out_eol = (col==COLS-1). out_last = out_eol && (row==ROWS-1). These are combinational from the registered row/col or registered alongside them; either way they are valid in the same cycle as out_valid.
- DONE, exactly one cycle:
  - done=1, out_valid=0.
  - pop_count is updated to the final sum, including the last cell, and is visible in this cycle. It holds until the next DONE or reset.
  - Next state is IDLE. busy drops the cycle after DONE.
- Frame latency with out_ready held high: start edge -> first valid 1 cycle; ROWS*COLS transfer cycles; then 1 DONE cycle. Total busy = ROWS*COLS+1 cycles.
- The array may keep evolving during a frame. Output reflects the snapshot only; cells changes after the start edge are ignored.
- start while busy (STREAM or DONE) is ignored. It is neither queued nor restarts the frame.
- start asserted in the cycle right after done, when the block is in IDLE, begins a new frame. Back-to-back frames are therefore separated by exactly one idle cycle.
- Reset mid-frame aborts immediately to reset values. No done pulse is produced and pop_count=0.
- Degenerate ROWS=1 or COLS=1:
  - COLS=1: out_eol is always 1.
  - ROWS=COLS=1: the first cell has out_last=1, and DONE follows its transfer.
- Width rules:
  - acc and pop_count are PW bits and cannot overflow (max ROWS*COLS).
  - Row/col counters never exceed ROWS-1 or COLS-1.

Test Plan:
- 8x8 array, cells=64'h0, out_ready=1, pulse start -> 64 transfers, all out_bit=0; out_eol on cols 7; out_last on transfer 64; done pulse next cycle; pop_count=0; busy high 65 cycles.
- cells=64'h8000_0000_0000_0001 (cells (0,0) and (7,7)), ready=1 -> out_bit=1 only on the first and last transfers; pop_count=2.
- Glider pattern loaded, out_ready toggled 1/0 pseudo-randomly -> out_* hold stable while ready=0; transferred sequence equals snapshot in row-major order; pop_count=5.
- Change cells to all-ones one cycle after start; assert start again mid-frame -> output still matches the original snapshot; no restart; exactly one done; pop_count unchanged by the ignored start.
- Assert reset at transfer 20 -> next cycle out_valid=0, busy=0, pop_count=0, no done. A following start runs a full clean 64-cell frame.
- ROWS=1, COLS=1, cells=1, start, ready=0 for 3 cycles then 1 -> out_valid is held 3 cycles with out_eol=out_last=1; done one cycle after the transfer; pop_count=1.
